pwm_driver: RTL and testbench

- Downstream consumer of the 16-bit motor command word the SPI slave writes (YAW_PWM / PITCH_PWM); one instance per axis.
- Resynchronises the word into the system clock domain and generates a fixed-frequency PWM.
- Drives H-bridge direction lines, with an enforced dead interval on every direction reversal.
- Duty and direction updates take effect only at period boundaries, so there are no runt pulses.

---
 rtl/pwm_driver.sv | 160 ++++++++++++++++
 tb/tb_pwm_driver.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_driver.sv
// pwm_driver: per-axis motor PWM generator.
// Takes the 16-bit command word {reserved, dir, duty[13:0]} from the SPI slave
// and brings it into the clk domain, waiting until the word has held steady.
// Produces a fixed-frequency PWM plus H-bridge direction lines.
// Every direction reversal forces a dead interval with the bridge fully off.
// New duty and direction values are applied only at period boundaries.
module pwm_driver #(
  parameter int PWM_DATA_WIDTH = 16,
  parameter int PERIOD         = 10000,
  parameter int DEAD_TIME      = 100,
  parameter int CNT_WIDTH      = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PWM_DATA_WIDTH-1:0] PWM_DATA,
  output logic                      PWM_OUT,
  output logic                      DIR_A,
  output logic                      DIR_B,
  output logic                      PERIOD_START
);

  // Dead counter only has to reach DEAD_TIME-1.
  localparam int DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(PERIOD - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DEAD_W-1:0]    DEAD_LAST = DEAD_W'(DEAD_TIME - 1);
  localparam logic [DEAD_W-1:0]    DEAD_ONE  = DEAD_W'(1);

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Input resynchronisation and stability filtering
  logic [PWM_DATA_WIDTH-1:0] sync1_reg;
  logic [PWM_DATA_WIDTH-1:0] sync2_reg;
  logic [PWM_DATA_WIDTH-1:0] sync3_reg;
  logic [PWM_DATA_WIDTH-1:0] pending_word_reg;

  // Period generator state
  state_t                state_reg;
  logic [DEAD_W-1:0]     dead_cnt_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  active_dir_reg;
  logic [CNT_WIDTH-1:0]  active_duty_reg;
  logic                  pwm_out_reg;
  logic                  dir_a_reg;
  logic                  dir_b_reg;
  logic                  period_start_reg;

  logic                  pend_dir;
  logic [CNT_WIDTH-1:0]  pend_duty;
  logic                  unused_reserved;

  assign pend_dir        = pending_word_reg[CNT_WIDTH];
  assign pend_duty       = pending_word_reg[CNT_WIDTH-1:0];
  // The reserved upper bit(s) are carried through the synchroniser but never used.
  assign unused_reserved = ^pending_word_reg[PWM_DATA_WIDTH-1:CNT_WIDTH+1];
  assign cnt_next        = cnt_reg + CNT_ONE;

  // Two-flop synchroniser plus a stability stage.
  // pending only takes a word that matched on two consecutive cycles.
  // This way a word caught mid-write by the SPI side is never used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg        <= '0;
      sync2_reg        <= '0;
      sync3_reg        <= '0;
      pending_word_reg <= '0;
    end else begin
      sync1_reg <= PWM_DATA;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      if (sync2_reg == sync3_reg) begin
        pending_word_reg <= sync2_reg;
      end
    end
  end

  // DEAD/RUN sequencer. Outputs are registered from the values the counter takes
  // on the same edge, so PWM_OUT/PERIOD_START stay aligned with the counter value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_DEAD;
      dead_cnt_reg     <= '0;
      cnt_reg          <= '0;
      active_dir_reg   <= 1'b0;
      active_duty_reg  <= '0;
      pwm_out_reg      <= 1'b0;
      dir_a_reg        <= 1'b0;
      dir_b_reg        <= 1'b0;
      period_start_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_DEAD: begin
          cnt_reg <= '0;
          if (dead_cnt_reg == DEAD_LAST) begin
            // Leave DEAD. Use whatever command is pending on this exact cycle.
            dead_cnt_reg     <= '0;
            state_reg        <= ST_RUN;
            active_dir_reg   <= pend_dir;
            active_duty_reg  <= pend_duty;
            period_start_reg <= 1'b1;
            pwm_out_reg      <= (pend_duty != '0);
            dir_a_reg        <= ~pend_dir;
            dir_b_reg        <= pend_dir;
          end else begin
            dead_cnt_reg     <= dead_cnt_reg + DEAD_ONE;
            period_start_reg <= 1'b0;
            pwm_out_reg      <= 1'b0;
            dir_a_reg        <= 1'b0;
            dir_b_reg        <= 1'b0;
          end
        end

        ST_RUN: begin
          if (cnt_reg == LAST_CNT) begin
            cnt_reg <= '0;
            if (pend_dir == active_dir_reg) begin
              // Same direction: take the new duty for the next period.
              active_duty_reg  <= pend_duty;
              period_start_reg <= 1'b1;
              pwm_out_reg      <= (pend_duty != '0);
            end else begin
              // Reversal: switch the bridge fully off before driving the other leg.
              state_reg        <= ST_DEAD;
              dead_cnt_reg     <= '0;
              period_start_reg <= 1'b0;
              pwm_out_reg      <= 1'b0;
              dir_a_reg        <= 1'b0;
              dir_b_reg        <= 1'b0;
            end
          end else begin
            cnt_reg          <= cnt_next;
            period_start_reg <= 1'b0;
            pwm_out_reg      <= (cnt_next < active_duty_reg);
          end
        end

        default: begin
          state_reg        <= ST_DEAD;
          dead_cnt_reg     <= '0;
          cnt_reg          <= '0;
          period_start_reg <= 1'b0;
          pwm_out_reg      <= 1'b0;
          dir_a_reg        <= 1'b0;
          dir_b_reg        <= 1'b0;
        end
      endcase
    end
  end

  assign PWM_OUT      = pwm_out_reg;
  assign DIR_A        = dir_a_reg;
  assign DIR_B        = dir_b_reg;
  assign PERIOD_START = period_start_reg;

endmodule

// File: tb/tb_pwm_driver.sv
// Testbench for pwm_driver (PERIOD=100, DEAD_TIME=10).
// The stimulus process steps a behavioural reference model and queues the
// expected output vector for every cycle.
// A separate monitor pops one entry per cycle and compares it with the DUT.
module tb_pwm_driver;

  localparam int PER  = 100;
  localparam int DEAD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PWM_DATA;
  logic        PWM_OUT;
  logic        DIR_A;
  logic        DIR_B;
  logic        PERIOD_START;

  always #5 clk = ~clk;

  pwm_driver #(
    .PWM_DATA_WIDTH(16),
    .PERIOD        (PER),
    .DEAD_TIME     (DEAD),
    .CNT_WIDTH     (14)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .PWM_DATA    (PWM_DATA),
    .PWM_OUT     (PWM_OUT),
    .DIR_A       (DIR_A),
    .DIR_B       (DIR_B),
    .PERIOD_START(PERIOD_START)
  );

  int checks = 0;
  int errors = 0;

  // Expected {PERIOD_START, PWM_OUT, DIR_A, DIR_B}, one entry per cycle
  logic [3:0] exp_q[$];

  // ---------------- reference model ----------------
  // hist[k] = command word sampled k edges ago.
  // The command is accepted once two consecutive samples (2 and 3 edges old) agree.
  logic [15:0] hist[4];
  logic [15:0] m_pend;
  bit          m_run;
  int          m_dead;   // cycles already spent in the dead interval
  int          m_pos;    // position inside the current period
  bit          m_dir;
  int          m_duty;

  logic [15:0] cur_d;
  logic        cur_r;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) hist[i] = 16'h0000;
    m_pend = 16'h0000;
    m_run  = 0;
    m_dead = 0;
    m_pos  = 0;
    m_dir  = 0;
    m_duty = 0;
  endfunction

  function automatic void model_edge(input logic [15:0] d);
    bit pdir;
    int pduty;
    pdir  = m_pend[14];
    pduty = int'(m_pend[13:0]);
    if (!m_run) begin
      if (m_dead == DEAD - 1) begin
        m_run  = 1;
        m_pos  = 0;
        m_dir  = pdir;
        m_duty = pduty;
        m_dead = 0;
      end else begin
        m_dead++;
      end
    end else if (m_pos == PER - 1) begin
      if (pdir == m_dir) begin
        m_duty = pduty;
        m_pos  = 0;
      end else begin
        m_run  = 0;
        m_dead = 0;
        m_pos  = 0;
      end
    end else begin
      m_pos++;
    end
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = d;
    if (hist[2] == hist[3]) m_pend = hist[2];
  endfunction

  function automatic logic [3:0] model_out();
    logic [3:0] v;
    v = 4'b0000;
    if (m_run) begin
      v[3] = (m_pos == 0);
      v[2] = (m_pos < m_duty);
      v[1] = ~m_dir;
      v[0] = m_dir;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  // One clock: let the edge happen, advance the model, drive new inputs, queue expectation.
  task automatic tick(input logic [15:0] d, input logic r);
    @(posedge clk);
    if (!cur_r) model_edge(cur_d);
    #1;
    PWM_DATA = d;
    rst      = r;
    cur_d    = d;
    cur_r    = r;
    if (r) model_reset();
    exp_q.push_back(model_out());
  endtask

  task automatic run(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) tick(d, 1'b0);
  endtask

  // Hold d until the model reaches RUN position p (bounded).
  task automatic wait_pos(input logic [15:0] d, input int p);
    int n;
    n = 0;
    while (!(m_run && m_pos == p) && n < 4 * PER) begin
      tick(d, 1'b0);
      n++;
    end
    checks++;
    if (!(m_run && m_pos == p)) begin
      errors++;
      $display("FAIL wait_pos: position %0d not reached (got run=%0d pos=%0d)", p, m_run, m_pos);
    end
  endtask

  // Hold d until the model has spent k cycles in DEAD (bounded).
  task automatic wait_dead(input logic [15:0] d, input int k);
    int n;
    n = 0;
    while (!(!m_run && m_dead == k) && n < 4 * PER) begin
      tick(d, 1'b0);
      n++;
    end
    checks++;
    if (!(!m_run && m_dead == k)) begin
      errors++;
      $display("FAIL wait_dead: dead count %0d not reached (got run=%0d dead=%0d)", k, m_run, m_dead);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int hi_cnt = 0;
  int per_n  = 0;

  always @(negedge clk) begin
    logic [3:0] e;
    logic [3:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {PERIOD_START, PWM_OUT, DIR_A, DIR_B};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got start/pwm/a/b=%b required %b", $time, got, e);
      end
      checks++;
      if (DIR_A === 1'b1 && DIR_B === 1'b1) begin
        errors++;
        $display("FAIL shoot_through t=%0t got DIR_A=1 DIR_B=1 required not both 1", $time);
      end
      if (PERIOD_START === 1'b1) begin
        if (per_n > 0) $display("period %0d done: high cycles=%0d", per_n, hi_cnt);
        per_n++;
        hi_cnt = 0;
      end
      if (PWM_OUT === 1'b1) hi_cnt++;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] rd;
    int          hold;

    rst      = 1'b1;
    PWM_DATA = 16'h0032;
    cur_d    = 16'h0032;
    cur_r    = 1'b1;
    model_reset();

    // Reset held, then release with duty 50, dir 0
    tick(16'h0032, 1'b1);
    tick(16'h0032, 1'b1);
    tick(16'h0032, 1'b1);
    run(16'h0032, 250);

    // Mid-period duty change at counter ~30
    wait_pos(16'h0032, 30);
    run(16'h0014, 220);

    // Direction reversal to dir 1, duty 50
    run(16'h4032, 250);

    // Duty 0, full (100), saturated (0x3FFF)
    run(16'h0000, 250);
    run(16'h0064, 200);
    run(16'h3FFF, 200);

    // Bit15 must be ignored
    run(16'hBFFF, 200);

    // Fast toggling input, then settle on 0x0020
    for (int i = 0; i < 20; i++) tick((i % 2 == 0) ? 16'h0010 : 16'h0020, 1'b0);
    run(16'h0020, 220);

    // Mid-period reversal that reverts before wrap: no dead interval
    wait_pos(16'h0020, 20);
    run(16'h4020, 30);
    run(16'h0020, 200);

    // Async reset at counter 40 in RUN
    wait_pos(16'h0028, 40);
    tick(16'h0028, 1'b1);
    tick(16'h0028, 1'b1);
    run(16'h0028, 150);

    // Async reset in the middle of the dead interval
    tick(16'h0028, 1'b1);
    wait_dead(16'h0028, 5);
    tick(16'h0028, 1'b1);
    run(16'h0028, 150);

    // Randomised commands and hold times
    for (int i = 0; i < 25; i++) begin
      rd   = 16'($urandom_range(0, 120));
      rd[14] = 1'($urandom_range(0, 1));
      rd[15] = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 150);
      if ($urandom_range(0, 9) == 0) tick(rd, 1'b1);
      run(rd, hold);
    end
    run(16'h0010, 120);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
